// File: rtl/rbzero_pkg.sv
// -----------------------------------------------------------------------------
// rbzero_pkg
// Shared definitions for the rbzero SPI register front end:
//   - default component widths (position Q6.9, direction Q2.10, colour BBGGRR)
//   - command codes and frame lengths (4-bit command + two components)
//   - reset values of every core-facing register
//   - receiver FSM state type
// -----------------------------------------------------------------------------
package rbzero_pkg;

  localparam int DEF_POS_W = 15;
  localparam int DEF_DIR_W = 12;
  localparam int DEF_COL_W = 6;
  localparam int CMD_W     = 4;

  localparam logic [3:0] CMD_SET_POS    = 4'h0;
  localparam logic [3:0] CMD_SET_FACING = 4'h1;
  localparam logic [3:0] CMD_SET_VPLANE = 4'h2;
  localparam logic [3:0] CMD_SET_COLOR  = 4'h3;

  // Total frame lengths in bits, command included.
  localparam int LEN_POS   = CMD_W + 2 * DEF_POS_W;  // 34
  localparam int LEN_DIR   = CMD_W + 2 * DEF_DIR_W;  // 28
  localparam int LEN_COLOR = CMD_W + 2 * DEF_COL_W;  // 16

  localparam logic [5:0] BIT_CNT_MAX = 6'd63;

  localparam logic [DEF_POS_W-1:0] POS_RESET      = 15'h0C00;  // 6.0
  localparam logic [DEF_DIR_W-1:0] FACING_X_RESET = 12'h400;   // +1.0
  localparam logic [DEF_DIR_W-1:0] FACING_Y_RESET = 12'h000;
  localparam logic [DEF_DIR_W-1:0] VPLANE_X_RESET = 12'h000;
  localparam logic [DEF_DIR_W-1:0] VPLANE_Y_RESET = 12'h200;   // +0.5
  localparam logic [DEF_COL_W-1:0] SKY_RESET      = 6'h15;
  localparam logic [DEF_COL_W-1:0] FLOOR_RESET    = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECV   = 2'b01,
    ST_COMMIT = 2'b10
  } rx_state_e;

endpackage

// File: rtl/rbzero_spi_sync.sv
// -----------------------------------------------------------------------------
// rbzero_spi_sync
// Brings one asynchronous SPI pin into the clk domain.
//   EDGE_DET = 1 : 3-FF chain; taps[0] is the synchronised level (2nd FF),
//                  taps[1] the one-cycle-delayed copy (3rd FF) so the user can
//                  form rise = taps[0] & ~taps[1], fall = ~taps[0] & taps[1].
//   EDGE_DET = 0 : plain 2-FF synchroniser; taps[0] is the level.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input
//   taps       : synchronised level (+ delayed copy when EDGE_DET = 1)
// RST_VAL is the value the whole chain resets to, so a pin already at that
// level when reset releases produces no edge.
// -----------------------------------------------------------------------------
module rbzero_spi_sync #(
  parameter int   EDGE_DET = 1,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic [EDGE_DET:0] taps
);

  logic [EDGE_DET+1:0] ff_r;

  // Shift the asynchronous pin through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_r <= {(EDGE_DET + 2){RST_VAL}};
    end else begin
      ff_r <= {ff_r[EDGE_DET:0], din};
    end
  end

  assign taps = ff_r[EDGE_DET+1:1];

endmodule

// File: rtl/rbzero_spi_regs.sv
// -----------------------------------------------------------------------------
// rbzero_spi_regs
// SPI-slave (mode 0, MSB first) register front end for the rbzero raycaster.
// Frames carry a 4-bit command followed by two components (X then Y, or sky
// then floor). A well-formed frame is written to a pending copy; pending
// copies reach the core-facing outputs only on i_load, so view vectors never
// change mid-frame.
// Ports:
//   clk, rst_n              : pixel clock, asynchronous active-low reset
//   i_sclk, i_mosi, i_ss_n  : SPI pins, asynchronous to clk (clk >= 4x sclk)
//   i_load                  : one-cycle frame-start pulse, applies pending values
//   o_player_x/y            : player position (Q6.9 unsigned)
//   o_facing_x/y            : facing vector (Q2.10 signed)
//   o_vplane_x/y            : viewplane vector (Q2.10 signed)
//   o_sky, o_floor          : colours (BBGGRR)
//   o_frame_err             : one-cycle pulse when a non-empty frame is discarded
// -----------------------------------------------------------------------------
module rbzero_spi_regs
  import rbzero_pkg::*;
#(
  parameter int POS_W = DEF_POS_W,
  parameter int DIR_W = DEF_DIR_W,
  parameter int COL_W = DEF_COL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sclk,
  input  logic             i_mosi,
  input  logic             i_ss_n,
  input  logic             i_load,
  output logic [POS_W-1:0] o_player_x,
  output logic [POS_W-1:0] o_player_y,
  output logic [DIR_W-1:0] o_facing_x,
  output logic [DIR_W-1:0] o_facing_y,
  output logic [DIR_W-1:0] o_vplane_x,
  output logic [DIR_W-1:0] o_vplane_y,
  output logic [COL_W-1:0] o_sky,
  output logic [COL_W-1:0] o_floor,
  output logic             o_frame_err
);

  localparam int POS_FRAME = CMD_W + 2 * POS_W;
  localparam int DIR_FRAME = CMD_W + 2 * DIR_W;
  localparam int COL_FRAME = CMD_W + 2 * COL_W;
  localparam int SHIFT_W_A = (POS_FRAME > DIR_FRAME) ? POS_FRAME : DIR_FRAME;
  localparam int SHIFT_W   = (SHIFT_W_A > COL_FRAME) ? SHIFT_W_A : COL_FRAME;

  // ---------------------------------------------------------------------------
  // Pin synchronisation. sclk and ss_n reset to 0: a select already low at
  // reset release gives no falling edge, and a select already high gives only
  // a rising edge, which the idle receiver ignores.
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_taps_s;
  logic [1:0] ss_taps_s;
  logic [0:0] mosi_taps_s;

  rbzero_spi_sync #(.EDGE_DET(1), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk),
    .rst_n (rst_n),
    .din (i_sclk),
    .taps (sclk_taps_s)
  );

  rbzero_spi_sync #(.EDGE_DET(1), .RST_VAL(1'b0)) u_sync_ss (
    .clk (clk),
    .rst_n (rst_n),
    .din (i_ss_n),
    .taps (ss_taps_s)
  );

  rbzero_spi_sync #(.EDGE_DET(0), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst_n (rst_n),
    .din (i_mosi),
    .taps (mosi_taps_s)
  );

  logic sclk_rise_s;
  logic ss_level_s;
  logic ss_rise_s;
  logic ss_fall_s;
  logic mosi_s;

  assign sclk_rise_s = sclk_taps_s[0] & ~sclk_taps_s[1];
  assign ss_level_s  = ss_taps_s[0];
  assign ss_rise_s   = ss_taps_s[0] & ~ss_taps_s[1];
  assign ss_fall_s   = ~ss_taps_s[0] & ss_taps_s[1];
  assign mosi_s      = mosi_taps_s[0];

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_e state_r;
  rx_state_e state_nxt_s;
  logic      clr_s;
  logic      shift_s;
  logic      commit_s;

  logic [SHIFT_W-1:0] shift_r;
  logic [5:0]         bit_cnt_r;

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath strobes. A new frame can only open on a falling
  // select edge, so bits after a reset are ignored until the select toggles.
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 1'b0;
    shift_s     = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ss_fall_s) begin
          state_nxt_s = ST_RECV;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (ss_rise_s) begin
          state_nxt_s = ST_COMMIT;
        end else if (sclk_rise_s && !ss_level_s) begin
          shift_s = 1'b1;
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      ST_COMMIT: begin
        commit_s = 1'b1;
        if (ss_fall_s) begin
          state_nxt_s = ST_RECV;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= {SHIFT_W{1'b0}};
      bit_cnt_r <= 6'd0;
    end else if (clr_s) begin
      shift_r   <= {SHIFT_W{1'b0}};
      bit_cnt_r <= 6'd0;
    end else if (shift_s) begin
      shift_r <= {shift_r[SHIFT_W-2:0], mosi_s};
      if (bit_cnt_r != BIT_CNT_MAX) begin
        bit_cnt_r <= bit_cnt_r + 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame decode. The command sits in the first four bits received, so its
  // position in the shift register depends on how many bits arrived; it is
  // only looked for at the three legal lengths.
  // ---------------------------------------------------------------------------
  logic [3:0] frame_cmd_s;
  logic       frame_ok_s;

  // Locate the command and check that the length matches it.
  always_comb begin
    frame_cmd_s = 4'hF;
    frame_ok_s  = 1'b0;
    case (bit_cnt_r)
      6'(POS_FRAME): frame_cmd_s = shift_r[POS_FRAME-1 -: CMD_W];
      6'(DIR_FRAME): frame_cmd_s = shift_r[DIR_FRAME-1 -: CMD_W];
      6'(COL_FRAME): frame_cmd_s = shift_r[COL_FRAME-1 -: CMD_W];
      default:       frame_cmd_s = 4'hF;
    endcase
    case (frame_cmd_s)
      CMD_SET_POS:    frame_ok_s = (bit_cnt_r == 6'(POS_FRAME));
      CMD_SET_FACING: frame_ok_s = (bit_cnt_r == 6'(DIR_FRAME));
      CMD_SET_VPLANE: frame_ok_s = (bit_cnt_r == 6'(DIR_FRAME));
      CMD_SET_COLOR:  frame_ok_s = (bit_cnt_r == 6'(COL_FRAME));
      default:        frame_ok_s = 1'b0;
    endcase
  end

  logic wr_pos_s;
  logic wr_facing_s;
  logic wr_vplane_s;
  logic wr_color_s;
  logic err_s;

  assign wr_pos_s    = commit_s & frame_ok_s & (frame_cmd_s == CMD_SET_POS);
  assign wr_facing_s = commit_s & frame_ok_s & (frame_cmd_s == CMD_SET_FACING);
  assign wr_vplane_s = commit_s & frame_ok_s & (frame_cmd_s == CMD_SET_VPLANE);
  assign wr_color_s  = commit_s & frame_ok_s & (frame_cmd_s == CMD_SET_COLOR);
  // An empty frame (select pulse without clocks) is dropped silently.
  assign err_s       = commit_s & ~frame_ok_s & (bit_cnt_r != 6'd0);

  // Frame error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= err_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Register groups. In every group the load is written before the commit:
  // a load coinciding with a commit copies the old pending value and the new
  // value stays pending (flag set again) for the next load.
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0] pos_x_pend_r, pos_y_pend_r;
  logic [DIR_W-1:0] fac_x_pend_r, fac_y_pend_r;
  logic [DIR_W-1:0] vpl_x_pend_r, vpl_y_pend_r;
  logic [COL_W-1:0] sky_pend_r, floor_pend_r;
  logic             pos_flag_r, fac_flag_r, vpl_flag_r, col_flag_r;

  // Position group: pending copy, flag and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_pend_r <= POS_W'(POS_RESET);
      pos_y_pend_r <= POS_W'(POS_RESET);
      pos_flag_r   <= 1'b0;
      o_player_x   <= POS_W'(POS_RESET);
      o_player_y   <= POS_W'(POS_RESET);
    end else begin
      if (i_load && pos_flag_r) begin
        o_player_x <= pos_x_pend_r;
        o_player_y <= pos_y_pend_r;
        pos_flag_r <= 1'b0;
      end
      if (wr_pos_s) begin
        pos_x_pend_r <= shift_r[2*POS_W-1 -: POS_W];
        pos_y_pend_r <= shift_r[POS_W-1:0];
        pos_flag_r   <= 1'b1;
      end
    end
  end

  // Facing group: pending copy, flag and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fac_x_pend_r <= DIR_W'(FACING_X_RESET);
      fac_y_pend_r <= DIR_W'(FACING_Y_RESET);
      fac_flag_r   <= 1'b0;
      o_facing_x   <= DIR_W'(FACING_X_RESET);
      o_facing_y   <= DIR_W'(FACING_Y_RESET);
    end else begin
      if (i_load && fac_flag_r) begin
        o_facing_x <= fac_x_pend_r;
        o_facing_y <= fac_y_pend_r;
        fac_flag_r <= 1'b0;
      end
      if (wr_facing_s) begin
        fac_x_pend_r <= shift_r[2*DIR_W-1 -: DIR_W];
        fac_y_pend_r <= shift_r[DIR_W-1:0];
        fac_flag_r   <= 1'b1;
      end
    end
  end

  // Viewplane group: pending copy, flag and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpl_x_pend_r <= DIR_W'(VPLANE_X_RESET);
      vpl_y_pend_r <= DIR_W'(VPLANE_Y_RESET);
      vpl_flag_r   <= 1'b0;
      o_vplane_x   <= DIR_W'(VPLANE_X_RESET);
      o_vplane_y   <= DIR_W'(VPLANE_Y_RESET);
    end else begin
      if (i_load && vpl_flag_r) begin
        o_vplane_x <= vpl_x_pend_r;
        o_vplane_y <= vpl_y_pend_r;
        vpl_flag_r <= 1'b0;
      end
      if (wr_vplane_s) begin
        vpl_x_pend_r <= shift_r[2*DIR_W-1 -: DIR_W];
        vpl_y_pend_r <= shift_r[DIR_W-1:0];
        vpl_flag_r   <= 1'b1;
      end
    end
  end

  // Colour group: pending copy, flag and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sky_pend_r   <= COL_W'(SKY_RESET);
      floor_pend_r <= COL_W'(FLOOR_RESET);
      col_flag_r   <= 1'b0;
      o_sky        <= COL_W'(SKY_RESET);
      o_floor      <= COL_W'(FLOOR_RESET);
    end else begin
      if (i_load && col_flag_r) begin
        o_sky      <= sky_pend_r;
        o_floor    <= floor_pend_r;
        col_flag_r <= 1'b0;
      end
      if (wr_color_s) begin
        sky_pend_r   <= shift_r[2*COL_W-1 -: COL_W];
        floor_pend_r <= shift_r[COL_W-1:0];
        col_flag_r   <= 1'b1;
      end
    end
  end

endmodule
